// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens and widths used by the word serializer.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;
  localparam int BIT_CNT_W   = 4;

  localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 4'd9;

endpackage

// File: rtl/tmds_word_serializer_if.sv
// Ready/valid character interface between a TMDS encoder channel and the serializer.
interface tmds_word_serializer_if;
  import tmds_pkg::*;

  logic [TMDS_WORD_W-1:0] wordIn;
  logic                   wordValid;
  logic                   wordReady;

  modport master (output wordIn, output wordValid, input wordReady);
  modport slave  (input wordIn, input wordValid, output wordReady);

endinterface

// File: rtl/tmds_word_serializer_popcount8.sv
// popcount8: combinational ones counter for an 8-bit slice.
module popcount8 (
  input  logic [7:0] data,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + 4'(data[i]);
    end
  end

endmodule

// File: rtl/tmds_word_serializer.sv
// 10:1 TMDS character serializer, LSB first, idle token on underrun.
// Optional running DC disparity monitor enabled with macro DISPARITY_MON_EN.
module tmds_word_serializer
  import tmds_pkg::*;
#(
  parameter logic [TMDS_WORD_W-1:0] IDLE_WORD  = TMDS_CTRL_00,
  parameter int                     DISP_WIDTH = 6
) (
  input  logic                         encoderSerialClock,
  input  logic                         resetN,
  tmds_word_serializer_if.slave        word,
  output logic                         tmdsSerialOut,
  output logic                         loadStrobe,
  output logic                         underrun,
  output logic [3:0]                   onesInWord,
  output logic signed [DISP_WIDTH-1:0] runningDisparity
);

  logic [TMDS_WORD_W-1:0] shift_reg;
  logic [BIT_CNT_W-1:0]   bit_count;
  logic [TMDS_WORD_W-1:0] next_word;
  logic [3:0]             low_ones;
  logic                   load;

  assign load           = (bit_count == LAST_BIT);
  assign word.wordReady = load;
  assign next_word      = word.wordValid ? word.wordIn : IDLE_WORD;
  assign tmdsSerialOut  = shift_reg[0];

  popcount8 u_popcount8 (
    .data  (next_word[7:0]),
    .count (low_ones)
  );

  // A reset parks the counter on the last bit so the first edge after release loads.
  always_ff @(posedge encoderSerialClock or negedge resetN) begin
    if (!resetN) begin
      shift_reg  <= '0;
      bit_count  <= LAST_BIT;
      loadStrobe <= 1'b0;
      underrun   <= 1'b0;
      onesInWord <= '0;
    end else if (load) begin
      shift_reg  <= next_word;
      bit_count  <= '0;
      loadStrobe <= 1'b1;
      underrun   <= !word.wordValid;
      onesInWord <= low_ones;
    end else begin
      shift_reg  <= shift_reg >> 1;
      bit_count  <= bit_count + 1'b1;
      loadStrobe <= 1'b0;
      underrun   <= 1'b0;
    end
  end

`ifdef DISPARITY_MON_EN
  localparam int SUM_W = ((DISP_WIDTH > 6) ? DISP_WIDTH : 6) + 2;
  localparam logic signed [SUM_W-1:0] DISP_MAX = SUM_W'((2 ** (DISP_WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] DISP_MIN = -DISP_MAX - SUM_W'(1);

  logic [3:0]              word_ones;
  logic signed [5:0]       step;
  logic signed [SUM_W-1:0] disp_sum;
  logic signed [SUM_W-1:0] disp_next;

  assign word_ones = low_ones + 4'(next_word[8]) + 4'(next_word[9]);
  assign step      = $signed({1'b0, word_ones, 1'b0}) - 6'sd10;

  // Sum in a wider signed domain, then clamp to the output range.
  always_comb begin
    disp_sum  = {{(SUM_W-DISP_WIDTH){runningDisparity[DISP_WIDTH-1]}}, runningDisparity}
              + {{(SUM_W-6){step[5]}}, step};
    disp_next = disp_sum;
    if (disp_sum > DISP_MAX) begin
      disp_next = DISP_MAX;
    end else if (disp_sum < DISP_MIN) begin
      disp_next = DISP_MIN;
    end
  end

  always_ff @(posedge encoderSerialClock or negedge resetN) begin
    if (!resetN) begin
      runningDisparity <= '0;
    end else if (load) begin
      runningDisparity <= disp_next[DISP_WIDTH-1:0];
    end
  end
`else
  assign runningDisparity = '0;
`endif

endmodule

// File: tb/tb_tmds_word_serializer.sv
// Directed self-checking bench for tmds_word_serializer (expects DISPARITY_MON_EN optional).
module tb_tmds_word_serializer;

  logic              clk = 1'b0;
  logic              resetN;
  logic              tmdsSerialOut;
  logic              loadStrobe;
  logic              underrun;
  logic [3:0]        onesInWord;
  logic signed [5:0] runningDisparity;
  int                checkCount = 0;
  int                failCount  = 0;

  localparam logic [9:0] IDLE_CHAR = 10'b1101010100;

  tmds_word_serializer_if bus ();

  tmds_word_serializer #(
    .IDLE_WORD  (10'b1101010100),
    .DISP_WIDTH (6)
  ) dut (
    .encoderSerialClock (clk),
    .resetN             (resetN),
    .word               (bus),
    .tmdsSerialOut      (tmdsSerialOut),
    .loadStrobe         (loadStrobe),
    .underrun           (underrun),
    .onesInWord         (onesInWord),
    .runningDisparity   (runningDisparity)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Disparity is only tracked when the monitor is built; otherwise it stays 0.
  function automatic logic [31:0] expDisp(input int value);
`ifdef DISPARITY_MON_EN
    return 32'(value);
`else
    return (value == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Called at a negedge where wordReady is high; returns at the next such negedge.
  task automatic applyStimulus(input logic valid, input logic [9:0] wordVal,
                               input logic [9:0] expChar, input int expOnes,
                               input int expDispVal);
    int readyCount;
    readyCount = 0;
    bus.wordValid = valid;
    bus.wordIn    = wordVal;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bit%0d", k), 32'(tmdsSerialOut), 32'(expChar[k]));
      if (k == 0) begin
        checkOutput("loadStrobe", 32'(loadStrobe), 32'd1);
        checkOutput("underrun", 32'(underrun), 32'(!valid));
        checkOutput("onesInWord", 32'(onesInWord), 32'(expOnes));
        checkOutput("disparity", 32'(runningDisparity), expDisp(expDispVal));
      end else begin
        checkOutput("strobeLow", 32'(loadStrobe), 32'd0);
      end
      if (bus.wordReady) readyCount++;
      if (k == 4) bus.wordIn = ~wordVal;
    end
    checkOutput("readyDuty", 32'(readyCount), 32'd1);
  endtask

  initial begin
    resetN        = 1'b0;
    bus.wordValid = 1'b0;
    bus.wordIn    = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstSerial", 32'(tmdsSerialOut), 32'd0);
    checkOutput("rstOnes", 32'(onesInWord), 32'd0);
    checkOutput("rstDisp", 32'(runningDisparity), 32'd0);
    checkOutput("rstStrobe", 32'(loadStrobe), 32'd0);
    resetN = 1'b1;
    #1;
    checkOutput("readyAfterRst", 32'(bus.wordReady), 32'd1);

    applyStimulus(1'b1, 10'h3FF, 10'h3FF, 8, 10);
    applyStimulus(1'b1, 10'h3FF, 10'h3FF, 8, 20);
    applyStimulus(1'b1, 10'h3FF, 10'h3FF, 8, 30);
    applyStimulus(1'b1, 10'h3FF, 10'h3FF, 8, 31);
    applyStimulus(1'b1, 10'h000, 10'h000, 0, 21);
    applyStimulus(1'b0, 10'h2AB, IDLE_CHAR, 3, 21);
    applyStimulus(1'b1, 10'b1010101011, 10'b1010101011, 5, 23);
    applyStimulus(1'b1, 10'h0FF, 10'h0FF, 8, 29);
    applyStimulus(1'b1, 10'h300, 10'h300, 0, 23);

    // Mid-word reset: abort during bit 4 of 10'h3F0.
    bus.wordValid = 1'b1;
    bus.wordIn    = 10'h3F0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abortBit%0d", k), 32'(tmdsSerialOut), (k == 4) ? 32'd1 : 32'd0);
    end
    resetN = 1'b0;
    #1;
    checkOutput("abortSerial", 32'(tmdsSerialOut), 32'd0);
    checkOutput("abortOnes", 32'(onesInWord), 32'd0);
    checkOutput("abortDisp", 32'(runningDisparity), 32'd0);
    checkOutput("abortReady", 32'(bus.wordReady), 32'd1);
    @(negedge clk);
    resetN = 1'b1;
    applyStimulus(1'b1, 10'b1010101011, 10'b1010101011, 5, 2);

    bus.wordValid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
